// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring checker.
// Provides the FSM state type, a one-step ring rotation and the index-width helper.
package ring_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } ring_state_e;

    localparam int RING_MAX_W = 64;

    function automatic int idx_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Rotate the low w bits of v by one place: bit i -> bit i+1, bit w-1 -> bit 0.
    function automatic logic [RING_MAX_W-1:0] rotl1(input logic [RING_MAX_W-1:0] v,
                                                     input int w);
        logic [RING_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < RING_MAX_W - 1; i++) begin
            if (i < w - 1) r[i+1] = v[i];
        end
        for (int i = 0; i < RING_MAX_W; i++) begin
            if (i == w - 1) r[0] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ring_seq_checker_decode.sv
// Combinational one-hot decoder: popcount==1 legality check and OR-reduction encoder.
module ring_onehot_decode #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] ring_in,
    output logic [IDX_W-1:0] idx_nxt,
    output logic             is_onehot
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] ones;

    always_comb begin
        ones    = '0;
        idx_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + CW'(ring_in[i]);
            if (ring_in[i]) idx_nxt = idx_nxt | IDX_W'(i);
        end
        is_onehot = (ones == CW'(1));
    end

endmodule

// File: rtl/ring_seq_checker.sv
// Receive-side checker/decoder for the one-hot ring counter: lock FSM and error counter.
// Optional RING_CHK_FLYWHEEL_EN: tolerate one isolated mismatch in LOCK by coasting on the prediction.
module ring_seq_checker
    import ring_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8,
    localparam int IDX_W   = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] ring_in,
    output logic [IDX_W-1:0] idx,
    output logic             idx_valid,
    output logic             onehot_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    ring_state_e      state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [GW-1:0]    good_q, good_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             idx_valid_q, idx_valid_d;
    logic             onehot_err_q, onehot_err_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [WIDTH-1:0] expected;
    logic [IDX_W-1:0] dec_idx;
    logic             is_onehot;
    logic             match;

    ring_onehot_decode #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_decode (
        .ring_in   (ring_in),
        .idx_nxt   (dec_idx),
        .is_onehot (is_onehot)
    );

    assign expected = WIDTH'(rotl1(RING_MAX_W'(prev_q), WIDTH));
    assign match    = (ring_in == expected);

`ifdef RING_CHK_FLYWHEEL_EN
    logic             miss_q, miss_d;
    logic [IDX_W-1:0] exp_idx;
    // idx always tracks prev, so the predicted index is simply the next ring position.
    assign exp_idx = (idx_q == IDX_W'(WIDTH - 1)) ? '0 : idx_q + IDX_W'(1);
`endif

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_d       = good_q;
        idx_d        = idx_q;
        idx_valid_d  = 1'b0;
        onehot_err_d = 1'b0;
        err_pulse_d  = 1'b0;
        err_count_d  = err_count_q;
`ifdef RING_CHK_FLYWHEEL_EN
        miss_d       = miss_q;
`endif
        if (en) begin
            onehot_err_d = !is_onehot;
            if (is_onehot) begin
                idx_d       = dec_idx;
                idx_valid_d = 1'b1;
                prev_d      = ring_in;
            end
            case (state_q)
                HUNT: begin
                    if (is_onehot) begin
                        state_d = SYNC;
                        good_d  = '0;
                    end
                end
                SYNC: begin
                    if (!is_onehot) begin
                        state_d = HUNT;
                    end else if (match) begin
                        good_d = good_q + GW'(1);
                        if (good_q == GW'(LOCK_CNT - 1)) state_d = LOCK;
                    end else begin
                        good_d = '0;
                    end
`ifdef RING_CHK_FLYWHEEL_EN
                    miss_d = 1'b0;
`endif
                end
                LOCK: begin
                    if (match) begin
`ifdef RING_CHK_FLYWHEEL_EN
                        miss_d = 1'b0;
`endif
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
`ifdef RING_CHK_FLYWHEEL_EN
                        if (!miss_q) begin
                            miss_d      = 1'b1;
                            prev_d      = expected;
                            idx_d       = exp_idx;
                            idx_valid_d = 1'b1;
                        end else begin
                            miss_d  = 1'b0;
                            state_d = HUNT;
                        end
`else
                        state_d = HUNT;
`endif
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            prev_q       <= '0;
            good_q       <= '0;
            idx_q        <= '0;
            idx_valid_q  <= 1'b0;
            onehot_err_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
`ifdef RING_CHK_FLYWHEEL_EN
            miss_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_q       <= good_d;
            idx_q        <= idx_d;
            idx_valid_q  <= idx_valid_d;
            onehot_err_q <= onehot_err_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
`ifdef RING_CHK_FLYWHEEL_EN
            miss_q       <= miss_d;
`endif
        end
    end

    assign idx        = idx_q;
    assign idx_valid  = idx_valid_q;
    assign onehot_err = onehot_err_q;
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;
    assign locked     = (state_q == LOCK);

endmodule
